// File: rtl/tnn_neuron_seq.sv
// -----------------------------------------------------------------------------
// tnn_neuron_seq
//
// Sequential ternary-weight threshold neuron. A vector of N_IN unsigned inputs
// is captured on the input handshake. Each input i is then added when
// POS_MASK[i]=1 or subtracted when 0, LANES inputs per cycle, over
// K = ceil(N_IN/LANES) cycles. The final signed sum is compared against THRESH
// and the one-bit decision is presented on the output handshake.
//
// Parameters
//   N_IN      number of neuron inputs (1..64)
//   IN_W      unsigned width of each input (1..8)
//   LANES     inputs accumulated per cycle (1..N_IN)
//   POS_MASK  per-input sign: 1 adds, 0 subtracts
//   THRESH    signed firing threshold (out_bit = sum >= THRESH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    N_IN*IN_W bits, input i at [i*IN_W +: IN_W]
//   in_valid   input vector valid
//   in_ready   high only while idle, ready to accept a vector
//   out_bit    neuron decision, valid under out_valid
//   out_valid  high only while a decision is presented
//   out_ready  consumer accepts the decision
//   out_sum    (only with TNN_SUM_OUT_EN) signed final accumulator,
//              registered together with out_bit
//
// Build option
//   TNN_SUM_OUT_EN  define to add the out_sum port and its register.
// -----------------------------------------------------------------------------
module tnn_neuron_seq #(
    parameter int                N_IN     = 7,
    parameter int                IN_W     = 2,
    parameter int                LANES    = 2,
    parameter logic [N_IN-1:0]   POS_MASK = 7'b1011101,
    parameter int signed         THRESH   = 1,
    // Magnitude bound N_IN*(2^IN_W-1) plus a sign bit; the sum cannot overflow.
    localparam int               ACC_W    = $clog2(N_IN * ((1 << IN_W) - 1) + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*IN_W-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_bit,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef TNN_SUM_OUT_EN
    ,
    output logic signed [ACC_W-1:0] out_sum
`endif
);

    localparam int K     = (N_IN + LANES - 1) / LANES;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    // Elaboration-time range checks on the configuration.
    if (N_IN < 1 || N_IN > 64) begin : g_bad_n_in
        $error("tnn_neuron_seq: N_IN must be in 1..64");
    end
    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $error("tnn_neuron_seq: IN_W must be in 1..8");
    end
    if (LANES < 1 || LANES > N_IN) begin : g_bad_lanes
        $error("tnn_neuron_seq: LANES must be in 1..N_IN");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    logic [N_IN*IN_W-1:0]     data_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic [IDX_W-1:0]         idx_q;
    logic                     last_step;
    logic                     out_bit_q;
    logic signed [ACC_W-1:0]  contrib [N_IN];

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_step = (idx_q == IDX_W'(K - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE here means in_ready is low on this edge,
                // so no new vector can be taken in the release cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-input signed contributions. An input only contributes in the cycle
    // whose lane group contains it; padding positions beyond N_IN never exist,
    // so they are implicitly zero.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < N_IN; i++) begin : g_term
        logic signed [ACC_W-1:0] mag;
        logic                    in_group;

        assign mag      = ACC_W'(data_q[i*IN_W +: IN_W]);
        assign in_group = (idx_q == IDX_W'(i / LANES));
        assign contrib[i] = !in_group   ? '0 :
                            POS_MASK[i] ? mag : -mag;
    end

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            lane_sum = lane_sum + contrib[i];
        end
    end

    assign acc_next = acc_q + lane_sum;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            out_bit_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                ACC: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_step) begin
                        // Sign-extend before comparing so negative sums and
                        // negative thresholds order correctly.
                        out_bit_q <= (int'(acc_next) >= THRESH);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_bit = out_bit_q;

`ifdef TNN_SUM_OUT_EN
    logic signed [ACC_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == ACC && last_step) begin
            sum_q <= acc_next;
        end
    end

    assign out_sum = sum_q;
`endif

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// -----------------------------------------------------------------------------
// tb_tnn_neuron_seq
//
// Bench for tnn_neuron_seq. Five instances cover the configurations of
// interest: the default neuron (LANES=2), a single-cycle all-subtract neuron
// with a negative threshold, and the default weights at LANES 1, 3 and 7.
// Expected decisions come from a plain weighted-sum reference function.
// Define TNN_SUM_OUT_EN on both files to also check out_sum.
// -----------------------------------------------------------------------------
module tb_tnn_neuron_seq;

    localparam int NDUT = 5;
    localparam int              N_TAB      [NDUT] = '{7, 5, 7, 7, 7};
    localparam int              LANES_TAB  [NDUT] = '{2, 5, 1, 3, 7};
    localparam int              THRESH_TAB [NDUT] = '{1, -2, 1, 1, 1};
    localparam logic [6:0]      MASK_TAB   [NDUT] = '{7'b1011101, 7'b0000000,
                                                      7'b1011101, 7'b1011101,
                                                      7'b1011101};

    logic        clk;
    logic        rst;
    logic [13:0] in_data_v   [NDUT];
    logic        in_valid_v  [NDUT];
    logic        in_ready_v  [NDUT];
    logic        out_bit_v   [NDUT];
    logic        out_valid_v [NDUT];
    logic        out_ready_v [NDUT];

`ifdef TNN_SUM_OUT_EN
    logic signed [5:0] sum0;
    logic signed [4:0] sum1;
    logic signed [5:0] sum2;
    logic signed [5:0] sum3;
    logic signed [5:0] sum4;
`endif

    int checks;
    int passes;
    int fails;

    // -------------------------------------------------------------------------
    // DUT instances
    // -------------------------------------------------------------------------
    tnn_neuron_seq #(.N_IN(7), .IN_W(2), .LANES(2), .POS_MASK(7'b1011101), .THRESH(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .out_bit(out_bit_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0])
`ifdef TNN_SUM_OUT_EN
        , .out_sum(sum0)
`endif
    );

    tnn_neuron_seq #(.N_IN(5), .IN_W(2), .LANES(5), .POS_MASK(5'b00000), .THRESH(-2)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data_v[1][9:0]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .out_bit(out_bit_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1])
`ifdef TNN_SUM_OUT_EN
        , .out_sum(sum1)
`endif
    );

    tnn_neuron_seq #(.N_IN(7), .IN_W(2), .LANES(1), .POS_MASK(7'b1011101), .THRESH(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data_v[2]), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .out_bit(out_bit_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2])
`ifdef TNN_SUM_OUT_EN
        , .out_sum(sum2)
`endif
    );

    tnn_neuron_seq #(.N_IN(7), .IN_W(2), .LANES(3), .POS_MASK(7'b1011101), .THRESH(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data_v[3]), .in_valid(in_valid_v[3]),
        .in_ready(in_ready_v[3]), .out_bit(out_bit_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready_v[3])
`ifdef TNN_SUM_OUT_EN
        , .out_sum(sum3)
`endif
    );

    tnn_neuron_seq #(.N_IN(7), .IN_W(2), .LANES(7), .POS_MASK(7'b1011101), .THRESH(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data_v[4]), .in_valid(in_valid_v[4]),
        .in_ready(in_ready_v[4]), .out_bit(out_bit_v[4]), .out_valid(out_valid_v[4]),
        .out_ready(out_ready_v[4])
`ifdef TNN_SUM_OUT_EN
        , .out_sum(sum4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

    // -------------------------------------------------------------------------
    // Reference model: ideal weighted sum of the first n inputs.
    // -------------------------------------------------------------------------
    function automatic int ref_sum(input logic [13:0] v, input int n, input logic [6:0] m);
        int s;
        int x;
        s = 0;
        for (int i = 0; i < n; i++) begin
            x = int'((v >> (2 * i)) & 14'h3);
            if (((m >> i) & 7'h1) != 7'h0) s = s + x;
            else                           s = s - x;
        end
        return s;
    endfunction

    function automatic int dut_sum(input int d);
`ifdef TNN_SUM_OUT_EN
        case (d)
            0:       return int'(sum0);
            1:       return int'(sum1);
            2:       return int'(sum2);
            3:       return int'(sum3);
            default: return int'(sum4);
        endcase
`else
        return d * 0;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Drivers
    // -------------------------------------------------------------------------
    // Offers vec to DUT d and waits for out_valid. lat counts cycles from the
    // acceptance edge to out_valid. With scramble set, in_valid stays high and
    // in_data keeps changing while the DUT is busy.
    task automatic start_and_wait(input int d, input logic [13:0] vec,
                                  input bit scramble, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready_v[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (in_ready_v[d] !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL ready_wait dut%0d: in_ready=%b, required 1", d, in_ready_v[d]);
        end
        in_data_v[d]  = vec;
        in_valid_v[d] = 1'b1;
        @(negedge clk);
        if (scramble) in_data_v[d] = 14'($urandom);
        else          in_valid_v[d] = 1'b0;
        lat = 0;
        while (out_valid_v[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (scramble) in_data_v[d] = 14'($urandom);
        end
        in_valid_v[d] = 1'b0;
        if (out_valid_v[d] !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL valid_wait dut%0d: out_valid=%b after %0d cycles, required 1",
                     d, out_valid_v[d], lat);
        end
    endtask

    task automatic run_txn(input int d, input logic [13:0] vec, input bit scramble,
                           output logic ob, output int lat, output int sm);
        start_and_wait(d, vec, scramble, lat);
        ob = out_bit_v[d];
        sm = dut_sum(d);
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0 || out_bit_v[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state dut%0d: ready/valid/bit=%b%b%b, required 101",
                         d, in_ready_v[d], out_valid_v[d], out_bit_v[d]);
            end else passes++;
`ifdef TNN_SUM_OUT_EN
            checks++;
            if (dut_sum(d) != 0) begin
                fails++;
                $display("FAIL reset_sum dut%0d: out_sum=%0d, required 0", d, dut_sum(d));
            end else passes++;
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: ready/valid=%b%b, required 10",
                     in_ready_v[0], out_valid_v[0]);
        end else passes++;
    endtask

    task automatic test_defaults();
        logic [13:0] vecs  [4] = '{14'h3FFF, 14'h0C0C, 14'h0001, 14'h0000};
        int          sums  [4] = '{9, -6, 1, 0};
        logic        bits  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        ob;
        int          lat;
        int          sm;
        for (int t = 0; t < 4; t++) begin
            run_txn(0, vecs[t], 1'b0, ob, lat, sm);
            checks++;
            if (ob !== bits[t]) begin
                fails++;
                $display("FAIL default_bit[%0d]: out_bit=%b, required %b", t, ob, bits[t]);
            end else passes++;
            checks++;
            if (lat != 4) begin
                fails++;
                $display("FAIL default_latency[%0d]: %0d cycles, required 4", t, lat);
            end else passes++;
`ifdef TNN_SUM_OUT_EN
            checks++;
            if (sm != sums[t]) begin
                fails++;
                $display("FAIL default_sum[%0d]: out_sum=%0d, required %0d", t, sm, sums[t]);
            end else passes++;
`else
            sm = sums[t];
`endif
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_and_wait(0, 14'h0C0C, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid_v[0] !== 1'b1 || out_bit_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0) begin
                fails++;
                $display("FAIL hold_done[%0d]: valid/bit/ready=%b%b%b, required 100",
                         c, out_valid_v[0], out_bit_v[0], in_ready_v[0]);
            end else passes++;
            in_valid_v[0] = (c == 1);
            in_data_v[0]  = 14'h3FFF;
            @(negedge clk);
        end
        // Offer a vector in the release cycle; it must not be taken on that edge.
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL release_idle: valid/ready=%b%b, required 01",
                     out_valid_v[0], in_ready_v[0]);
        end else passes++;
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL release_no_accept: in_ready=%b, required 1", in_ready_v[0]);
        end else passes++;
    endtask

    task automatic test_reset_mid_acc();
        logic ob;
        int   lat;
        int   sm;
        @(negedge clk);
        in_data_v[0]  = 14'h3FFF;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: ready/valid=%b%b, required 10",
                     in_ready_v[0], out_valid_v[0]);
        end else passes++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
                fails++;
                $display("FAIL aborted_result[%0d]: valid/ready=%b%b, required 01",
                         c, out_valid_v[0], in_ready_v[0]);
            end else passes++;
        end
        run_txn(0, 14'h0C0C, 1'b0, ob, lat, sm);
        checks++;
        if (ob !== 1'b0 || lat != 4) begin
            fails++;
            $display("FAIL after_abort: out_bit=%b latency=%0d, required 0 and 4", ob, lat);
        end else passes++;
`ifdef TNN_SUM_OUT_EN
        checks++;
        if (sm != -6) begin
            fails++;
            $display("FAIL after_abort_sum: out_sum=%0d, required -6", sm);
        end else passes++;
`endif
    endtask

    task automatic test_small_cfg();
        logic ob;
        int   lat;
        int   sm;
        run_txn(1, 14'h0000, 1'b0, ob, lat, sm);
        checks++;
        if (ob !== 1'b1 || lat != 1) begin
            fails++;
            $display("FAIL small_zero: out_bit=%b latency=%0d, required 1 and 1", ob, lat);
        end else passes++;
        run_txn(1, 14'h0155, 1'b0, ob, lat, sm);
        checks++;
        if (ob !== 1'b0 || lat != 1) begin
            fails++;
            $display("FAIL small_ones: out_bit=%b latency=%0d, required 0 and 1", ob, lat);
        end else passes++;
`ifdef TNN_SUM_OUT_EN
        checks++;
        if (sm != -5) begin
            fails++;
            $display("FAIL small_ones_sum: out_sum=%0d, required -5", sm);
        end else passes++;
`endif
    endtask

    task automatic test_ignore_busy_inputs();
        logic [13:0] vec;
        logic        ob;
        int          lat;
        int          sm;
        int          es;
        for (int t = 0; t < 8; t++) begin
            vec = 14'($urandom);
            es  = ref_sum(vec, N_TAB[3], MASK_TAB[3]);
            run_txn(3, vec, 1'b1, ob, lat, sm);
            checks++;
            if (ob !== (es >= THRESH_TAB[3])) begin
                fails++;
                $display("FAIL busy_ignore[%0d] vec=%h: out_bit=%b, required %b",
                         t, vec, ob, (es >= THRESH_TAB[3]));
            end else passes++;
`ifdef TNN_SUM_OUT_EN
            checks++;
            if (sm != es) begin
                fails++;
                $display("FAIL busy_ignore_sum[%0d]: out_sum=%0d, required %0d", t, sm, es);
            end else passes++;
`endif
        end
    endtask

    task automatic test_random_sweep();
        int          dsel [3] = '{2, 3, 4};
        int          d;
        int          k;
        int          es;
        logic [13:0] vec;
        logic        eb;
        logic        ob;
        int          lat;
        int          sm;
        for (int s = 0; s < 3; s++) begin
            d = dsel[s];
            k = (N_TAB[d] + LANES_TAB[d] - 1) / LANES_TAB[d];
            for (int t = 0; t < 1000; t++) begin
                vec = 14'($urandom);
                es  = ref_sum(vec, N_TAB[d], MASK_TAB[d]);
                eb  = (es >= THRESH_TAB[d]);
                run_txn(d, vec, 1'b0, ob, lat, sm);
                checks++;
                if (ob !== eb || lat != k) begin
                    fails++;
                    $display("FAIL sweep lanes=%0d vec=%h: out_bit=%b latency=%0d, required %b and %0d",
                             LANES_TAB[d], vec, ob, lat, eb, k);
                end else passes++;
`ifdef TNN_SUM_OUT_EN
                checks++;
                if (sm != es) begin
                    fails++;
                    $display("FAIL sweep_sum lanes=%0d vec=%h: out_sum=%0d, required %0d",
                             LANES_TAB[d], vec, sm, es);
                end else passes++;
`endif
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst    = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_data_v[d]   = '0;
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        test_reset();
        test_defaults();
        test_backpressure();
        test_reset_mid_acc();
        test_small_cfg();
        test_ignore_busy_inputs();
        test_random_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
